// File: rtl/conv_pkg.sv
// Shared definitions for the conv33 front end: line-buffer FSM encoding and default geometry.
package conv_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } lb_state_t;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 6;
    localparam int unsigned PIX_W = 8;

endpackage

// File: rtl/line_buf3_if.sv
// Pixel-in / tap-out bundle for line_buf3; out_x/out_y exist only with LINE_BUF3_COORD_EN.
interface line_buf3_if #(
    parameter int unsigned W  = conv_pkg::IMG_W,
    parameter int unsigned H  = conv_pkg::IMG_H,
    parameter int unsigned DW = conv_pkg::PIX_W
);

    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] pix_in;
    logic          shift_en;
    logic [DW-1:0] pix_top;
    logic [DW-1:0] pix_mid;
    logic [DW-1:0] pix_bot;
    logic          frame_done;
`ifdef LINE_BUF3_COORD_EN
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;

    modport master (
        output in_valid, pix_in,
        input  in_ready, shift_en, pix_top, pix_mid, pix_bot, frame_done, out_x, out_y
    );
    modport slave (
        input  in_valid, pix_in,
        output in_ready, shift_en, pix_top, pix_mid, pix_bot, frame_done, out_x, out_y
    );
`else
    modport master (
        output in_valid, pix_in,
        input  in_ready, shift_en, pix_top, pix_mid, pix_bot, frame_done
    );
    modport slave (
        input  in_valid, pix_in,
        output in_ready, shift_en, pix_top, pix_mid, pix_bot, frame_done
    );
`endif

endinterface

// File: rtl/line_mem.sv
// One W x DW line of pixels: single write port, combinational read at the same address
// (read returns the old word during a write, i.e. read-before-write).
module line_mem #(
    parameter int unsigned W  = 8,
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(W)-1:0] addr,
    input  logic [DW-1:0]        wdata,
    output logic [DW-1:0]        rdata
);

    logic [DW-1:0] mem [W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_buf3.sv
// Raster-to-column line buffer producing zero-padded vertical tap triples for conv33.
// Optional centre-coordinate outputs under `LINE_BUF3_COORD_EN.
module line_buf3
    import conv_pkg::*;
#(
    parameter int unsigned W  = IMG_W,
    parameter int unsigned H  = IMG_H,
    parameter int unsigned DW = PIX_W
) (
    input  logic       clk,
    input  logic       rst,
    line_buf3_if.slave bus
);

    localparam int unsigned CXW = $clog2(W);
    localparam int unsigned RYW = $clog2(H);

    lb_state_t      state;
    logic [CXW-1:0] cx;
    logic [RYW-1:0] ry;
    logic           accept;
    logic           last_col;
    logic [DW-1:0]  a_rd;
    logic [DW-1:0]  b_rd;

    assign bus.in_ready = (state != FLUSH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_col     = (cx == CXW'(W - 1));

    // lineA takes the row leaving lineB; lineB takes every incoming row
    line_mem #(.W(W), .DW(DW)) u_line_a (
        .clk   (clk),
        .we    (accept && (state == RUN)),
        .addr  (cx),
        .wdata (b_rd),
        .rdata (a_rd)
    );

    line_mem #(.W(W), .DW(DW)) u_line_b (
        .clk   (clk),
        .we    (accept),
        .addr  (cx),
        .wdata (bus.pix_in),
        .rdata (b_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FILL;
            cx             <= '0;
            ry             <= '0;
            bus.shift_en   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.pix_top    <= '0;
            bus.pix_mid    <= '0;
            bus.pix_bot    <= '0;
`ifdef LINE_BUF3_COORD_EN
            bus.out_x      <= '0;
            bus.out_y      <= '0;
`endif
        end else begin
            bus.shift_en   <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (last_col) begin
                            cx    <= '0;
                            ry    <= RYW'(1);
                            state <= RUN;
                        end else begin
                            cx <= cx + CXW'(1);
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        // first centre row has no row above: mask the stale lineA word
                        bus.pix_top  <= (ry == RYW'(1)) ? '0 : a_rd;
                        bus.pix_mid  <= b_rd;
                        bus.pix_bot  <= bus.pix_in;
                        bus.shift_en <= 1'b1;
`ifdef LINE_BUF3_COORD_EN
                        bus.out_x    <= cx;
                        bus.out_y    <= ry - RYW'(1);
`endif
                        if (last_col) begin
                            cx <= '0;
                            if (ry == RYW'(H - 1)) state <= FLUSH;
                            else                   ry    <= ry + RYW'(1);
                        end else begin
                            cx <= cx + CXW'(1);
                        end
                    end
                end
                FLUSH: begin
                    bus.pix_top  <= a_rd;
                    bus.pix_mid  <= b_rd;
                    bus.pix_bot  <= '0;
                    bus.shift_en <= 1'b1;
`ifdef LINE_BUF3_COORD_EN
                    bus.out_x    <= cx;
                    bus.out_y    <= RYW'(H - 1);
`endif
                    if (last_col) begin
                        bus.frame_done <= 1'b1;
                        cx             <= '0;
                        ry             <= '0;
                        state          <= FILL;
                    end else begin
                        cx <= cx + CXW'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: doc/line_buf3.md
# line_buf3

Raster-to-column line buffer that feeds the `conv33` convolution stage.
- Accepts one pixel per handshake in row-major order for a W×H frame.
- For each centre pixel (y, x), emits the vertical tap triple `pix_top`/`pix_mid`/`pix_bot` = rows y-1/y/y+1 at column x, with a one-cycle `shift_en` strobe.
- Taps outside the frame are zero, so the taps and `shift_en` connect directly to `conv33`.
- One instance is used per colour channel.

## Interface
- `W`, default 8: columns per row; must be ≥ 2.
- `H`, default 6: rows per frame; must be ≥ 2.
- `DW`, default 8: pixel width in bits; unsigned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `in_valid` in 1: `pix_in` is valid this cycle.
- `in_ready` out 1: block accepts `pix_in`; a pixel transfers when `in_valid && in_ready`.
- `pix_in` in DW: next raster pixel.
- `shift_en` out 1: one-cycle strobe; the taps hold a new column.
- `pix_top` out DW: row y-1 tap, or 0 when y = 0.
- `pix_mid` out DW: row y tap.
- `pix_bot` out DW: row y+1 tap, or 0 when y = H-1.
- `frame_done` out 1: pulses together with the `shift_en` of centre (H-1, W-1).
- `out_x` out clog2(W): centre column. Present only with `LINE_BUF3_COORD_EN`.
- `out_y` out clog2(H): centre row. Present only with `LINE_BUF3_COORD_EN`.

## Operation
**Storage**
- Two W×DW line memories:
  - `lineA` holds row y-2.
  - `lineB` holds row y-1, relative to the incoming row y.
- Column counter `cx` runs 0..W-1. Row counter `ry` runs 0..H-1.

**FSM states**
- FILL (row 0 input):
  - `in_ready` = 1.
  - Each accept writes `lineB[cx]` ← `pix_in`. No `shift_en`.
  - When `cx` = W-1: `cx` wraps to 0, `ry` ← 1, go to RUN.
- RUN (input rows 1..H-1):
  - `in_ready` = 1.
  - Each accept at column `cx` registers: `pix_top` ← (`ry` = 1 ? 0 : `lineA[cx]`), `pix_mid` ← `lineB[cx]`, `pix_bot` ← `pix_in`.
  - In the same cycle: `shift_en` ← 1, `lineA[cx]` ← `lineB[cx]`, `lineB[cx]` ← `pix_in`.
  - The emitted centre row is `ry`-1.
  - At `cx` = W-1: wrap `cx`. If `ry` = H-1, go to FLUSH with `cx` = 0; otherwise increment `ry`.
- FLUSH (emit centre row H-1, no input):
  - `in_ready` = 0. Inputs are ignored.
  - Every cycle: `pix_top` ← `lineA[cx]`, `pix_mid` ← `lineB[cx]`, `pix_bot` ← 0, `shift_en` ← 1.
  - After W cycles: `frame_done` pulses with the last column, `cx` = `ry` = 0, go to FILL.

**Output behaviour**
- The next frame starts immediately after FLUSH; no frame-start input exists.
- Cycles with no accepted pixel in FILL/RUN: `shift_en` = 0 and the taps hold their last value.
- Arithmetic is copy/mux only; no width growth. Pixels are unsigned.
  - The downstream stage may reinterpret the taps as signed; the tap bits are passed unchanged.

## Timing
- Reset values: state = FILL, `cx` = `ry` = 0, `shift_en` = 0, `frame_done` = 0, all taps = 0, `in_ready` = 1 (combinational from state). `out_x` = `out_y` = 0.
- Line memories are not cleared. Stale contents are never emitted because of the `ry` = 1 zero mux and the FILL overwrite.
- Latency: taps and `shift_en` are registered, valid the cycle after the accepting edge.
- First `shift_en` of a frame follows acceptance of pixel (1, 0), i.e. W+1 accepts into the frame.
- Throughput: one column per cycle.
  - A frame takes W·H accept cycles plus W flush cycles.
  - `in_ready` is low for exactly W cycles per frame.
- Reset asserted mid-frame (any state): immediate return to the reset values. The next accepted pixel is treated as (0, 0).
- `in_valid` held high during FLUSH: no transfer, no counter change.

## Configuration
- `LINE_BUF3_COORD_EN` defined:
  - Adds `out_x`/`out_y` ports, registered alongside the taps with the centre coordinates.
  - In FLUSH, `out_y` = H-1.
- Undefined: the ports and their registers are absent. Tap/strobe behaviour is identical.

## Structure
- Shared package `conv_pkg`:
  - FSM state encoding `lb_state_t` (FILL, RUN, FLUSH).
  - Default geometry constants `IMG_W` = 8, `IMG_H` = 6, `PIX_W` = 8.
- One sub-module, `line_mem`: a W×DW single-write, single-read-address memory, instantiated twice. Read and write use the same `cx` address, with read-before-write in the same cycle.

## Test plan
Unless stated otherwise: W = 8, H = 6, pixel = 32·y, `in_valid` held at 1.
- After reset, stream row 0: `shift_en` = 0 for the first 8 accepts. The first strobe, after accepting (1, 0), gives `pix_top` = 0, `pix_mid` = 0, `pix_bot` = 32.
- Centre row 2: every strobe gives `pix_top` = 32, `pix_mid` = 64, `pix_bot` = 96.
- After the 48th accept: `in_ready` = 0 for exactly 8 cycles.
  - Each of those cycles gives `pix_top` = 128, `pix_mid` = 160, `pix_bot` = 0.
  - `frame_done` pulses on the 8th cycle. `in_ready` returns to 1 the next cycle.
- Insert random `in_valid` gaps (pixel = 16·(x^y)):
  - Strobes occur only the cycle after accepts.
  - The tap sequence matches a zero-padded golden model.
  - The strobe count per frame is 48.
- Assert `rst` at row 3, column 4; release, then stream a new frame of 7s. The first strobe gives top 0, mid 7, bot 7, with no stale data.
- With `LINE_BUF3_COORD_EN`: `out_x`/`out_y` step (0, 0) … (7, 5) across the 48 strobes, with (7, 5) coinciding with `frame_done`.
